// File: rtl/hdmi_timing_controller.sv
// 720p raster sequencer for the three TMDS encoders. Colour bars are built only with HDMI_TEST_PATTERN_EN defined.
// A position at cycle n reaches the encoder outputs at n+PIXEL_LATENCY+1. There is no backpressure: the pixel source must keep pace.
module hdmi_timing_controller #(
    parameter int H_ACTIVE      = 1280,
    parameter int H_FRONT       = 110,
    parameter int H_SYNC        = 40,
    parameter int H_BACK        = 220,
    parameter int V_ACTIVE      = 720,
    parameter int V_FRONT       = 5,
    parameter int V_SYNC        = 5,
    parameter int V_BACK        = 20,
    parameter int PIXEL_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        testPattern,
    output logic        pixelRequest,
    output logic [10:0] xCoord,
    output logic [9:0]  yCoord,
    input  logic        pixelValid,
    input  logic [23:0] pixelData,
    output logic        newFrame,
    output logic        blank,
    output logic [1:0]  syncBlue,
    output logic [1:0]  syncGreen,
    output logic [1:0]  syncRed,
    output logic [7:0]  dataBlue,
    output logic [7:0]  dataGreen,
    output logic [7:0]  dataRed,
    output logic        underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_ON  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0]  V_SYNC_OFF = 10'(V_ACTIVE + V_FRONT + V_SYNC);
`ifdef HDMI_TEST_PATTERN_EN
    localparam int DW = 7;
`else
    localparam int DW = 3;
`endif

    logic [10:0]   r_h_count;
    logic [9:0]    r_v_count;
    logic          r_run;
    logic          w_active;
    logic          w_hsync;
    logic          w_vsync;
    logic [DW-1:0] w_stage_in;
    logic [DW-1:0] r_dly [PIXEL_LATENCY];
    logic          w_d_active;
    logic          w_d_vsync;
    logic          w_d_hsync;
    logic          w_d_pattern;
    logic [23:0]   w_d_rgb;

    // r_run lags enable by one edge so the first running cycle sits at h=0, v=0
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            r_run     <= 1'b0;
            r_h_count <= '0;
            r_v_count <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                if (r_h_count == H_LAST) begin
                    r_h_count <= '0;
                    r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + 10'd1;
                end else begin
                    r_h_count <= r_h_count + 11'd1;
                end
            end
        end
    end

    assign w_active  = r_run && (r_h_count < H_ACT) && (r_v_count < V_ACT);
    assign w_hsync   = r_run && (r_h_count >= H_SYNC_ON) && (r_h_count < H_SYNC_OFF);
    assign w_vsync   = r_run && (r_v_count >= V_SYNC_ON) && (r_v_count < V_SYNC_OFF);
    assign xCoord    = r_h_count;
    assign yCoord    = r_v_count;
    assign newFrame  = r_run && (r_h_count == '0) && (r_v_count == '0);
    assign syncGreen = 2'b00;
    assign syncRed   = 2'b00;

`ifdef HDMI_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] w_bar;
    logic [2:0] w_d_bar;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (r_h_count >= 11'(k * BAR_W)) w_bar = 3'(k);
        end
    end

    // Pattern select travels with each pixel so a mid-line switch lands on the next pixel
    assign pixelRequest = w_active && !testPattern;
    assign w_stage_in   = {w_bar, testPattern, w_active, w_vsync, w_hsync};
    assign {w_d_bar, w_d_pattern} = r_dly[PIXEL_LATENCY-1][6:3];
    assign w_d_rgb      = w_d_pattern ? bar_rgb(w_d_bar) : pixelData;
`else
    logic w_unused_tp;
    assign w_unused_tp  = testPattern;
    assign pixelRequest = w_active;
    assign w_stage_in   = {w_active, w_vsync, w_hsync};
    assign w_d_pattern  = 1'b0;
    assign w_d_rgb      = pixelData;
`endif
    assign {w_d_active, w_d_vsync, w_d_hsync} = r_dly[PIXEL_LATENCY-1][2:0];

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            for (int i = 0; i < PIXEL_LATENCY; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_stage_in;
            for (int i = 1; i < PIXEL_LATENCY; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            blank     <= 1'b1;
            syncBlue  <= 2'b00;
            dataRed   <= '0;
            dataGreen <= '0;
            dataBlue  <= '0;
            if (reset) underrun <= 1'b0;
        end else begin
            blank    <= !w_d_active;
            syncBlue <= {w_d_vsync, w_d_hsync};
            if (w_d_active && (w_d_pattern || pixelValid)) begin
                {dataRed, dataGreen, dataBlue} <= w_d_rgb;
            end else begin
                dataRed   <= '0;
                dataGreen <= '0;
                dataBlue  <= '0;
                if (w_d_active) underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_controller.sv
// Scoreboarded bench: three instances at PIXEL_LATENCY 1, 2 and 8 on a shrunken raster.
module tb_hdmi_timing_controller;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int NI = 3;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic testPattern;
    bit   drop_arm;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int g, input int c,
                         input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", name, g, c, got, want);
        end
    endtask

    function automatic logic [23:0] pix(input int h, input int v);
        return {8'(h * 3 + 1), 8'(v * 7 + 2), 8'(h ^ v ^ 'h5A)};
    endfunction

    function automatic logic [23:0] bar_colour(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        logic        pixelRequest, newFrame, blank, underrun, pixelValid;
        logic [10:0] xCoord;
        logic [9:0]  yCoord;
        logic [23:0] pixelData;
        logic [1:0]  syncBlue, syncGreen, syncRed;
        logic [7:0]  dataBlue, dataGreen, dataRed;
        exp_t        q[$];

        hdmi_timing_controller #(
            .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
            .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
            .PIXEL_LATENCY(L)
        ) dut (
            .clock(clk), .reset(reset), .enable(enable), .testPattern(testPattern),
            .pixelRequest(pixelRequest), .xCoord(xCoord), .yCoord(yCoord),
            .pixelValid(pixelValid), .pixelData(pixelData), .newFrame(newFrame),
            .blank(blank), .syncBlue(syncBlue), .syncGreen(syncGreen), .syncRed(syncRed),
            .dataBlue(dataBlue), .dataGreen(dataGreen), .dataRed(dataRed),
            .underrun(underrun)
        );

        // Raster model, pixel source and expected-output producer
        initial begin : producer
            int c, start, k, h, v, e, e2;
            bit run, prev_ok, act, hsy, vsy, tpe, stv, pvb, sa, shs, svs, stp, exp_ur;
            int hist_h [16];
            int hist_v [16];
            bit hist_a [16];
            bit hist_hs [16];
            bit hist_vs [16];
            bit hist_tp [16];
            bit hist_ok [16];
            logic [23:0] rgb;
            logic [31:0] ev;
            run = 0; prev_ok = 0; start = 0; exp_ur = 0;
            for (int i = 0; i < 16; i++) begin
                hist_h[i] = 0; hist_v[i] = 0; hist_a[i] = 0; hist_hs[i] = 0;
                hist_vs[i] = 0; hist_tp[i] = 0; hist_ok[i] = 0;
            end
            pixelValid = 1'b0;
            pixelData  = 24'h0;
            forever begin
                @(negedge clk);
                c = cyc;
                if (!prev_ok) run = 0;
                else begin
                    if (!run) start = c;
                    run = 1;
                end
                prev_ok = enable && !reset;
                k = c - start;
                h = k % HT;
                v = (k / HT) % VT;
                act = run && (h < HA) && (v < VA);
                hsy = run && (h >= HA + HF) && (h < HA + HF + HS);
                vsy = run && (v >= VA + VF) && (v < VA + VF + VS);
`ifdef HDMI_TEST_PATTERN_EN
                tpe = testPattern;
`else
                tpe = 0;
`endif
                e = c % 16;
                hist_h[e] = h; hist_v[e] = v; hist_a[e] = act; hist_hs[e] = hsy;
                hist_vs[e] = vsy; hist_tp[e] = tpe; hist_ok[e] = prev_ok;

                check("pixelRequest", g, c, 32'(pixelRequest), 32'(act && !tpe));
                check("newFrame", g, c, 32'(newFrame), 32'(run && (k % FRAME == 0)));
                if (act && !tpe) begin
                    check("xCoord", g, c, 32'(xCoord), 32'(h));
                    check("yCoord", g, c, 32'(yCoord), 32'(v));
                end

                // Source answers the request made L cycles ago; one pixel is dropped while armed
                stv = (c >= L);
                e2 = 0;
                if (stv) begin
                    e2 = (c - L) % 16;
                    for (int j = 1; j <= L; j++) if (!hist_ok[(c - j) % 16]) stv = 0;
                end
                pvb = (c >= L) && hist_a[e2] && !hist_tp[e2]
                      && !(drop_arm && hist_h[e2] == 5 && hist_v[e2] == 2);
                pixelValid = pvb;
                pixelData  = pvb ? pix(hist_h[e2], hist_v[e2]) : 24'hBADBAD;

                if (reset) begin
                    exp_ur = 0;
                    ev = {1'b1, 6'b0, 24'h0, 1'b0};
                end else if (!enable) begin
                    ev = {1'b1, 6'b0, 24'h0, exp_ur};
                end else begin
                    sa  = stv && hist_a[e2];
                    shs = stv && hist_hs[e2];
                    svs = stv && hist_vs[e2];
                    stp = stv && hist_tp[e2];
                    rgb = 24'h0;
                    if (sa) begin
                        if (stp) rgb = bar_colour(hist_h[e2] / (HA / 8));
                        else if (pvb) rgb = pix(hist_h[e2], hist_v[e2]);
                        else exp_ur = 1;
                    end
                    ev = {!sa, svs, shs, 4'b0000, rgb, exp_ur};
                end
                q.push_back('{c + 1, ev});
            end
        end

        initial begin : monitor
            exp_t ex;
            forever begin
                @(negedge clk);
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
                if (q.size() > 0 && q[0].due == cyc) begin
                    ex = q.pop_front();
                    check("enc_out", g, cyc,
                          {blank, syncBlue, syncGreen, syncRed, dataRed, dataGreen, dataBlue, underrun},
                          ex.val);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; testPattern = 1'b0; drop_arm = 0;
        repeat (3) @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk); #1 enable = 1'b1;
        repeat (FRAME + 10) @(posedge clk); #1 drop_arm = 1;
        repeat (FRAME) @(posedge clk); #1 drop_arm = 0;
        repeat (FRAME / 2 + 5) @(posedge clk); #1 enable = 1'b0;
        repeat (6) @(posedge clk); #1 enable = 1'b1;
        repeat (FRAME + 30) @(posedge clk); #1 testPattern = 1'b1;
        repeat (FRAME) @(posedge clk); #1 testPattern = 1'b0;
        repeat (7) @(posedge clk); #1 testPattern = 1'b1;
        repeat (5) @(posedge clk); #1 testPattern = 1'b0;
        repeat (HT + 3) @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk); #1 reset = 1'b0;
        repeat (FRAME / 2) @(posedge clk); #1 enable = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
